// File: rtl/joy_cursor.sv
// joy_cursor: joystick direction to bounded X/Y cursor with auto-repeat and idle recentre.
// Define JOY_WRAP_EN to make coordinates wrap at the bounds instead of saturating.
module joy_cursor #(
    parameter int W          = 8,
    parameter int X_MAX      = 159,
    parameter int Y_MAX      = 119,
    parameter int X_HOME     = 80,
    parameter int Y_HOME     = 60,
    parameter int REPEAT     = 4,
    parameter int IDLE_LIMIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid,
    input  logic [1:0]   dir,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         move,
    output logic         step,
    output logic         at_edge,
    output logic         timeout
);
    typedef enum logic {IDLE, HOLD} state_t;
    localparam int RW = REPEAT > 1 ? $clog2(REPEAT) : 1;
    localparam int IW = IDLE_LIMIT > 1 ? $clog2(IDLE_LIMIT) : 1;
    localparam logic [RW-1:0] RL = RW'(REPEAT - 1);
    localparam logic [IW-1:0] IL = IW'(IDLE_LIMIT - 1);
    localparam logic [W:0]    XM = (W+1)'(X_MAX);
    localparam logic [W:0]    YM = (W+1)'(Y_MAX);
    state_t        state, state_n;
    logic [1:0]    ldir, ldir_n;
    logic [RW-1:0] rep_cnt, rep_n;
    logic [IW-1:0] idle_cnt, idle_n;
    logic          homed, homed_n;
    logic [W-1:0]  x_n, y_n, cur, nv;
    logic          move_n, step_n, edge_n, to_n;
    logic          vert, inc, bound, blocked, attempt;
    logic [W:0]    lim, tgt;
    // Target is computed one bit wider so both overflow and underflow show up in tgt.
    always_comb begin
        vert  = ~dir[1];
        inc   = ~^dir;
        cur   = vert ? y : x;
        lim   = vert ? YM : XM;
        tgt   = inc ? {1'b0, cur} + 1'b1 : {1'b0, cur} - 1'b1;
        bound = inc ? tgt > lim : tgt[W];
`ifdef JOY_WRAP_EN
        nv      = bound ? (inc ? '0 : lim[W-1:0]) : tgt[W-1:0];
        blocked = 1'b0;
`else
        nv      = bound ? cur : tgt[W-1:0];
        blocked = bound;
`endif
    end
    always_comb begin
        state_n = state;
        ldir_n  = ldir;
        rep_n   = rep_cnt;
        idle_n  = idle_cnt;
        homed_n = homed;
        x_n     = x;
        y_n     = y;
        move_n  = move;
        step_n  = 1'b0;
        edge_n  = 1'b0;
        to_n    = 1'b0;
        attempt = state == IDLE ? valid : valid && (dir != ldir || rep_cnt == RL);
        if (state == IDLE) begin
            if (valid) begin
                state_n = HOLD;
                homed_n = 1'b0;
            end else if (!homed && IDLE_LIMIT != 0) begin
                idle_n = idle_cnt + 1'b1;
                if (idle_cnt == IL) begin
                    x_n     = W'(X_HOME);
                    y_n     = W'(Y_HOME);
                    to_n    = 1'b1;
                    homed_n = 1'b1;
                    idle_n  = '0;
                end
            end
        end else if (!valid) begin
            state_n = IDLE;
            idle_n  = '0;
        end else if (!attempt) begin
            rep_n = rep_cnt + 1'b1;
        end
        if (attempt) begin
            ldir_n = dir;
            rep_n  = '0;
            move_n = vert;
            x_n    = vert ? x : nv;
            y_n    = vert ? nv : y;
            step_n = !blocked;
            edge_n = blocked;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ldir     <= '0;
            rep_cnt  <= '0;
            idle_cnt <= '0;
            homed    <= 1'b1;
            x        <= W'(X_HOME);
            y        <= W'(Y_HOME);
            move     <= 1'b0;
            step     <= 1'b0;
            at_edge  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ldir     <= ldir_n;
            rep_cnt  <= rep_n;
            idle_cnt <= idle_n;
            homed    <= homed_n;
            x        <= x_n;
            y        <= y_n;
            move     <= move_n;
            step     <= step_n;
            at_edge  <= edge_n;
            timeout  <= to_n;
        end
    end
endmodule

// File: tb/tb_joy_cursor.sv
// tb_joy_cursor: randomized and directed checks of joy_cursor against a timestamp-based reference model.
module tb_joy_cursor;
    logic       clk = 0, reset = 1, valid = 0;
    logic [1:0] dir = 0;
    logic [7:0] x, y;
    logic       move, step, at_edge, timeout;
    joy_cursor dut (.clk(clk), .reset(reset), .valid(valid), .dir(dir), .x(x), .y(y),
                    .move(move), .step(step), .at_edge(at_edge), .timeout(timeout));
    always #5 clk = ~clk;
    int pass = 0, total = 0;
    int mx, my, t, t_att, t_drop, ld;
    bit mmove, mstep, medge, mto, hold, homed;
    function automatic logic [19:0] exp_o();
        return {mx[7:0], my[7:0], mmove, mstep, medge, mto};
    endfunction
    function automatic logic [19:0] act_o();
        return {x, y, move, step, at_edge, timeout};
    endfunction
    function automatic void attempt(int d);
        int nx = mx, ny = my;
        t_att = t;
        ld = d;
        mmove = d < 2;
        case (d)
            0: ny = ny + 1;
            1: ny = ny - 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
        endcase
`ifdef JOY_WRAP_EN
        if (nx < 0) nx = 159;
        if (nx > 159) nx = 0;
        if (ny < 0) ny = 119;
        if (ny > 119) ny = 0;
        mx = nx; my = ny; mstep = 1;
`else
        if (nx < 0 || nx > 159 || ny < 0 || ny > 119) medge = 1;
        else begin mx = nx; my = ny; mstep = 1; end
`endif
    endfunction
    // Attempts are scheduled by elapsed time since the last attempt / since release.
    function automatic void model(bit r, bit v, int d);
        t++;
        mstep = 0; medge = 0; mto = 0;
        if (r) begin
            mx = 80; my = 60; mmove = 0; hold = 0; homed = 1;
        end else if (!hold) begin
            if (v) begin hold = 1; homed = 0; attempt(d); end
            else if (!homed && t - t_drop == 16) begin mx = 80; my = 60; mto = 1; homed = 1; end
        end else if (!v) begin
            hold = 0; t_drop = t;
        end else if (d != ld || t - t_att == 4) attempt(d);
    endfunction
    task automatic tick(input bit r, input bit v, input int d);
        reset = r; valid = v; dir = 2'(d);
        @(posedge clk);
        model(r, v, d);
        #1;
    endtask
    task automatic test_reset();
        tick(1, 0, 0);
        total++;
        if ({x, y, move, step, at_edge, timeout} !== {8'd80, 8'd60, 4'b0}) $display("FAIL reset got %h exp %h", act_o(), {8'd80, 8'd60, 4'b0});
        else pass++;
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, 0);
            total++;
            if (act_o() !== exp_o()) $display("FAIL reset_idle cyc=%0d got %h exp %h", i, act_o(), exp_o());
            else pass++;
        end
    endtask
    task automatic test_repeat();
        for (int i = 0; i < 9; i++) begin
            tick(0, 1, 3);
            total++;
            if (act_o() !== exp_o()) $display("FAIL repeat cyc=%0d got %h exp %h", i, act_o(), exp_o());
            else pass++;
        end
        total++;
        if (x !== 8'd83) $display("FAIL repeat_x got %0d exp 83", x);
        else pass++;
        tick(0, 0, 0);
    endtask
    task automatic test_dir_change();
        tick(0, 1, 3);
        for (int i = 0; i < 7; i++) begin
            tick(0, 1, 0);
            total++;
            if (act_o() !== exp_o()) $display("FAIL dir_change cyc=%0d got %h exp %h", i, act_o(), exp_o());
            else pass++;
        end
        tick(0, 0, 0);
    endtask
    task automatic test_edges();
        for (int k = 0; k < 2; k++) begin
            int edges = 0;
            for (int i = 0; i < 340; i++) begin
                tick(0, 1, k == 0 ? 0 : 2);
                edges += int'(at_edge);
                total++;
                if (act_o() !== exp_o()) $display("FAIL edge dir=%0d cyc=%0d got %h exp %h", k, i, act_o(), exp_o());
                else pass++;
            end
`ifndef JOY_WRAP_EN
            total++;
            if (edges == 0) $display("FAIL edge_seen dir=%0d got 0 pulses exp >0", k);
            else pass++;
`endif
            tick(0, 0, 0);
        end
    endtask
    task automatic test_timeout();
        int pulses = 0;
        tick(1, 0, 0);
        tick(0, 1, 3);
        for (int i = 0; i < 66; i++) begin
            tick(0, 0, 0);
            pulses += int'(timeout);
            total++;
            if (act_o() !== exp_o()) $display("FAIL timeout cyc=%0d got %h exp %h", i, act_o(), exp_o());
            else pass++;
        end
        total++;
        if (pulses != 1) $display("FAIL timeout_count got %0d exp 1", pulses);
        else pass++;
    endtask
    task automatic test_reset_mid_hold();
        for (int i = 0; i < 6; i++) tick(0, 1, 1);
        tick(1, 1, 1);
        total++;
        if (act_o() !== exp_o()) $display("FAIL reset_hold got %h exp %h", act_o(), exp_o());
        else pass++;
        tick(0, 0, 0);
        total++;
        if (act_o() !== exp_o()) $display("FAIL reset_hold_idle got %h exp %h", act_o(), exp_o());
        else pass++;
    endtask
    task automatic test_random();
        bit v = 0;
        int d = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) v = !v;
            if ($urandom_range(0, 9) == 0) d = int'($urandom_range(0, 3));
            tick($urandom_range(0, 499) == 0, v, d);
            total++;
            if (act_o() !== exp_o()) $display("FAIL random cyc=%0d got %h exp %h", i, act_o(), exp_o());
            else pass++;
        end
    endtask
    initial begin
        t = 0; t_att = 0; t_drop = 0; ld = 0;
        test_reset();
        test_repeat();
        test_dir_change();
        test_edges();
        test_timeout();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/joy_cursor.md
# joy_cursor

Parametrised joystick cursor tracker. It converts a sampled 2-bit joystick direction into bounded X/Y cursor coordinates, with auto-repeat while a direction is held and an idle-timeout recentre. It sits between the joystick input synchroniser and the display/position consumers, and supersedes the fixed 8-bit tracker with its free-running reset counter.

## Interface
Parameters:
- `W`, 8: coordinate width in bits.
- `X_MAX`, 159: largest legal X; must be less than 2^W.
- `Y_MAX`, 119: largest legal Y; must be less than 2^W.
- `X_HOME`, 80: X value at reset and after timeout; must be ≤ `X_MAX`.
- `Y_HOME`, 60: Y value at reset and after timeout; must be ≤ `Y_MAX`.
- `REPEAT`, 4: cycles between auto-repeat steps while a direction is held; must be ≥ 1.
- `IDLE_LIMIT`, 16: consecutive idle cycles before recentre; 0 disables the timeout.

Ports (clock and reset first):
- `clk`  in  1: sole clock; all logic is on the rising edge.
- `reset`  in  1: reset, synchronous and active-high.
- `valid`  in  1: a joystick direction is asserted this cycle.
- `dir`  in  2: direction code. 00 = up (y+1), 01 = down (y−1), 10 = left (x−1), 11 = right (x+1).
- `x`  out  W: cursor X, registered.
- `y`  out  W: cursor Y, registered.
- `move`  out  1: axis of the last step attempt; 1 = vertical, 0 = horizontal. Held between attempts.
- `step`  out  1: one-cycle pulse when a coordinate changed.
- `at_edge`  out  1: one-cycle pulse when a step attempt was blocked at a bound. Never asserts in wrap mode.
- `timeout`  out  1: one-cycle pulse when an idle recentre occurs.

## Operation
- Reset values: `x`=`X_HOME`, `y`=`Y_HOME`, `move`=0, `step`=0, `at_edge`=0, `timeout`=0. Internal state after reset: state IDLE, `rep_cnt`=0, `idle_cnt`=0, `homed`=1.
- There are two states, IDLE and HOLD.
- Behaviour in IDLE:
  - `valid`=1: perform a step attempt with `dir`, latch `dir`, set `rep_cnt`=0, clear `homed`, go to HOLD.
  - `valid`=0 and `homed`=0 and `IDLE_LIMIT`≠0: increment `idle_cnt`. When it reaches `IDLE_LIMIT`, load the home coordinates, pulse `timeout`, set `homed`=1 and clear `idle_cnt`.
  - Only one timeout occurs per idle period. No timeout occurs after reset until a step attempt has been made.
- Behaviour in HOLD:
  - `valid`=0: go to IDLE with `idle_cnt`=0; no step.
  - `valid`=1 and `dir`≠latched direction: immediate step attempt, relatch, `rep_cnt`=0.
  - `valid`=1 and same direction: if `rep_cnt`=`REPEAT`−1, step attempt and `rep_cnt`=0; otherwise increment `rep_cnt`.
- Step attempt: sets `move` to the axis of `dir`. The target coordinate is computed in W+1 bits.
- Saturate mode (default):
  - up at `Y_MAX`, down at 0, left at 0 or right at `X_MAX` leaves the coordinate unchanged and pulses `at_edge`, not `step`.
  - Any other attempt updates the coordinate and pulses `step`.
- The other axis never changes during a step attempt.
- `reset` overrides everything in the same cycle, including a mid-hold step or a coincident timeout.

## Timing
- Latency is one cycle: inputs sampled at edge k produce the new `x`/`y`/`move`/`step`/`at_edge` values after edge k.
- `step` and `at_edge` are mutually exclusive and coincide with the updated coordinate.
- A held direction produces attempts at edges k, k+`REPEAT`, k+2·`REPEAT`, and so on. With `REPEAT`=1, an attempt occurs every cycle.
- If the direction changes while `valid` is held, the attempt occurs at the change edge and the repeat phase restarts from it.
- If `valid` drops at edge j, the timeout fires at edge j+`IDLE_LIMIT` when `valid` stays low. This assumes no step attempt occurred at edge j (none does, since the HOLD→IDLE edge performs no step).
- A `valid` pulse re-entering IDLE before the limit restarts the count from zero on the next drop.

## Configuration
- `JOY_WRAP_EN` defined: coordinates wrap instead of saturating.
  - up at `Y_MAX` → 0; down at 0 → `Y_MAX`; left at 0 → `X_MAX`; right at `X_MAX` → 0.
  - `step` pulses on every attempt; `at_edge` is tied to 0.
- `JOY_WRAP_EN` undefined: saturate behaviour as described in Operation.

## Test plan
- Reset, then 40 idle cycles: outputs are (80,60); `step`/`at_edge`/`timeout` never pulse; `move`=0.
- Hold `valid`=1 with dir=11 for 9 cycles (`REPEAT`=4): `step` pulses at cycles 0, 4 and 8; `x` goes 81, 82, 83; `move`=0.
- Change dir 11→00 on the cycle after the first step: immediate `y`=61 and `move`=1; the next repeat step lands 4 cycles later.
- Default build, start at y=119 and step up twice (via reset to `Y_HOME`=119 or repeated holds): `at_edge` pulses; `y` stays 119; `step`=0.
- Default build, a left step at x=0: `at_edge` pulses and `x` stays 0.
- `JOY_WRAP_EN` build at y=119 and x=0:
  - Up step: `y`=0 and `step`=1.
  - Left step: `x`=159.
- After one right step, release for 16 cycles: `timeout` pulses once and (x,y) returns to (80,60); no further pulse over 50 more idle cycles. Asserting `reset` during a held direction gives (80,60) and state IDLE next cycle.
